cva6_icache_tag_array: RTL and testbench
========================================

CVA6_ICACHE_TAG_ARRAY -- requirements
Module: cva6_icache_tag_array

Interface
REQ-001 Parameter NumSets, default 256, number of sets (power of two, >=2).
REQ-002 Parameter NumWays, default 4, number of ways (1..8).
REQ-003 Parameter TagWidth, default 44, tag bits per entry; SRAM word is {valid, tag}, TagWidth+1 bits.
REQ-004 Parameters impl_in_t/impl_out_t, default logic, SRAM implementation types, passed through.
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 impl_i  in  impl_in_t  SRAM implementation inputs, shared by all ways.
REQ-008 flush_i  in  1  request invalidation of all entries.
REQ-009 flush_busy_o  out  1  invalidation sweep in progress.
REQ-010 lookup_req_i / lookup_gnt_o  in/out  1  lookup handshake; transfer when both high.
REQ-011 lookup_idx_i  in  log2(NumSets)  set index; lookup_tag_i  in  TagWidth  compare tag.
REQ-012 rsp_valid_o  out  1  lookup result valid; hit_o  out  1; hit_way_o  out  NumWays one-hot.
REQ-013 multi_hit_o  out  1  more than one way matched (error flag).
REQ-014 victim_way_o  out  NumWays  one-hot replacement way, valid with rsp_valid_o.
REQ-015 fill_req_i / fill_gnt_o  in/out  1  fill handshake.
REQ-016 fill_idx_i, fill_tag_i, fill_way_i  in  log2(NumSets), TagWidth, NumWays  fill set, tag, one-hot way.

Function
REQ-017 States IDLE and FLUSH; FLUSH -> IDLE after writing set NumSets-1; IDLE -> FLUSH on flush_i.
REQ-018 FLUSH writes {0, 0} to every way of one set per cycle, counter 0..NumSets-1; sweep takes exactly NumSets cycles.
REQ-019 flush_i asserted during FLUSH restarts the counter at 0.
REQ-020 Priority flush > fill > lookup; fill_gnt_o = fill_req_i & IDLE & !flush_i; lookup_gnt_o = lookup_req_i & IDLE & !flush_i & !fill_req_i.
REQ-021 Fill writes {1, fill_tag_i} at fill_idx_i to every way set in fill_way_i; fill_way_i of zero writes nothing.
REQ-022 Lookup latency is one cycle: rsp_valid_o high the cycle after the grant, for exactly one cycle.
REQ-023 Index and tag registered at grant; way i hits if stored valid=1 and stored tag equals registered tag.
REQ-024 hit_o = OR of hit_way_o; multi_hit_o = popcount(hit_way_o) > 1; all hitting ways reported.
REQ-025 victim_way_o = lowest-index invalid way of the looked-up set; if all valid, round-robin pointer.
REQ-026 Round-robin pointer advances by one way (wrapping NumWays-1 -> 0) on each granted fill.
REQ-027 A response owed for a lookup granted in the cycle before flush_i is still delivered, from pre-flush data.
REQ-028 Outputs other than rsp_valid_o are don't-care when rsp_valid_o is low, but driven to zero.

Reset
REQ-029 Reset enters FLUSH with counter 0 and round-robin pointer 0; flush_busy_o=1, all other outputs 0.
REQ-030 Reset mid-sweep or mid-lookup aborts it; pending response discarded; sweep restarts at set 0.

Structure
REQ-031 Package cva6_icache_tag_pkg holds the state enum and the SRAM latency constant (1).
REQ-032 One tc_sram_impl per way, depth NumSets, width TagWidth+1, single port, latency 1.
REQ-033 Sub-module cva6_icache_victim_sel: valid vector and round-robin pointer in, one-hot victim out.

Verification (NumSets=16, NumWays=4, TagWidth=20)
REQ-034 Release reset -> flush_busy_o high exactly 16 cycles, lookup_gnt_o 0 throughout, then IDLE.
REQ-035 Fill idx 3 tag 0xABCDE way 0b0100; lookup idx 3 tag 0xABCDE -> next cycle hit_o=1, hit_way_o=0b0100.
REQ-036 Lookup idx 3 tag 0x12345 after REQ-035 -> hit_o=0, victim_way_o=0b0001.
REQ-037 Fill all four ways of idx 5, then lookup idx 5 miss -> victim_way_o=0b0001 (pointer wrapped to 0 after four fills).
REQ-038 Fill and lookup requested same cycle -> fill_gnt_o=1, lookup_gnt_o=0; lookup granted next cycle.
REQ-039 flush_i at sweep set 9 -> sweep restarts at 0, flush_busy_o high 16 more cycles; prior fills then miss.

Source files
------------

// File: rtl/cva6_icache_tag_array_pkg.sv
// Shared types and constants for the instruction-cache tag array.
// The package name is fixed by the integration; the file follows the block name.
package cva6_icache_tag_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_e;

   localparam int unsigned SramLatency = 1;

   // Index width that stays legal when only one element exists.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cva6_icache_tag_array_if.sv
// Lookup, fill and flush handshake bundle of the instruction-cache tag array.
interface cva6_icache_tag_array_if #(
   parameter int unsigned NumSets  = 256,
   parameter int unsigned NumWays  = 4,
   parameter int unsigned TagWidth = 44
);
   localparam int unsigned IdxWidth = $clog2(NumSets);

   logic                flush_i;
   logic                flush_busy_o;

   logic                lookup_req_i;
   logic                lookup_gnt_o;
   logic [IdxWidth-1:0] lookup_idx_i;
   logic [TagWidth-1:0] lookup_tag_i;

   logic                rsp_valid_o;
   logic                hit_o;
   logic [NumWays-1:0]  hit_way_o;
   logic                multi_hit_o;
   logic [NumWays-1:0]  victim_way_o;

   logic                fill_req_i;
   logic                fill_gnt_o;
   logic [IdxWidth-1:0] fill_idx_i;
   logic [TagWidth-1:0] fill_tag_i;
   logic [NumWays-1:0]  fill_way_i;

   modport master (
      output flush_i, lookup_req_i, lookup_idx_i, lookup_tag_i,
             fill_req_i, fill_idx_i, fill_tag_i, fill_way_i,
      input  flush_busy_o, lookup_gnt_o, rsp_valid_o, hit_o, hit_way_o,
             multi_hit_o, victim_way_o, fill_gnt_o
   );

   modport slave (
      input  flush_i, lookup_req_i, lookup_idx_i, lookup_tag_i,
             fill_req_i, fill_idx_i, fill_tag_i, fill_way_i,
      output flush_busy_o, lookup_gnt_o, rsp_valid_o, hit_o, hit_way_o,
             multi_hit_o, victim_way_o, fill_gnt_o
   );

endinterface

// File: rtl/cva6_icache_tag_array_victim_sel.sv
// Replacement choice: lowest invalid way, otherwise the round-robin way.
module cva6_icache_victim_sel #(
   parameter int unsigned NumWays  = 4,
   parameter int unsigned PtrWidth = 2
) (
   input  logic [NumWays-1:0]  valid,
   input  logic [PtrWidth-1:0] rr_ptr,
   output logic [NumWays-1:0]  victim
);

   always_comb begin
      victim = NumWays'(1) << rr_ptr;
      // Walk downwards so the lowest invalid way is the last one written.
      for (int unsigned i = NumWays; i > 0; i--) begin
         if (!valid[i-1]) begin
            victim = NumWays'(1) << (i - 1);
         end
      end
   end

endmodule

// File: rtl/tc_sram_impl.sv
// Single-port SRAM, one-cycle read latency; read data holds until the next read.
module tc_sram_impl #(
   parameter int unsigned NumWords  = 256,
   parameter int unsigned DataWidth = 45,
   parameter int unsigned AddrWidth = $clog2(NumWords),
   parameter type         impl_in_t  = logic,
   parameter type         impl_out_t = logic
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  impl_in_t             impl_i,
   output impl_out_t            impl_o,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [DataWidth-1:0] wdata_i,
   output logic [DataWidth-1:0] rdata_o
);

   logic [DataWidth-1:0] mem [NumWords];
   logic                 unused_impl;

   assign unused_impl = ^impl_i;
   assign impl_o      = '0;

   always_ff @(posedge clk_i) begin
      if (req_i && we_i) begin
         mem[addr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_o <= '0;
      end else if (req_i && !we_i) begin
         rdata_o <= mem[addr_i];
      end
   end

endmodule

// File: rtl/cva6_icache_tag_array.sv
// Instruction-cache tag array: per-way tag SRAMs with flush sweep, fill and
// one-cycle lookup returning hit ways and a replacement victim.
module cva6_icache_tag_array
   import cva6_icache_tag_pkg::*;
#(
   parameter int unsigned NumSets    = 256,
   parameter int unsigned NumWays    = 4,
   parameter int unsigned TagWidth   = 44,
   parameter type         impl_in_t  = logic,
   parameter type         impl_out_t = logic
) (
   input logic                    clk_i,
   input logic                    rst_i,
   input impl_in_t                impl_i,
   cva6_icache_tag_array_if.slave bus
);

   localparam int unsigned IdxWidth  = $clog2(NumSets);
   localparam int unsigned PtrWidth  = idx_width(NumWays);
   localparam int unsigned WordWidth = TagWidth + 1;

   state_e              state;
   logic                flush_busy_q;
   logic [IdxWidth-1:0] flush_cnt;
   logic [PtrWidth-1:0] rr_ptr;
   logic                rsp_pending;
   logic [TagWidth-1:0] lookup_tag_q;

   logic                fill_gnt;
   logic                lookup_gnt;

   logic [NumWays-1:0]   sram_req;
   logic                 sram_we;
   logic [IdxWidth-1:0]  sram_addr;
   logic [WordWidth-1:0] sram_wdata;
   logic [WordWidth-1:0] rdata [NumWays];
   impl_out_t            unused_impl_o [NumWays];

   logic [NumWays-1:0] way_valid;
   logic [NumWays-1:0] way_match;
   logic [NumWays-1:0] victim;

   assign fill_gnt   = bus.fill_req_i && (state == IDLE) && !bus.flush_i;
   assign lookup_gnt = bus.lookup_req_i && (state == IDLE) && !bus.flush_i && !bus.fill_req_i;

   always_comb begin
      sram_req   = '0;
      sram_we    = 1'b0;
      sram_addr  = bus.lookup_idx_i;
      sram_wdata = '0;
      if (state == FLUSH) begin
         sram_req  = '1;
         sram_we   = 1'b1;
         sram_addr = flush_cnt;
      end else if (fill_gnt) begin
         sram_req   = bus.fill_way_i;
         sram_we    = 1'b1;
         sram_addr  = bus.fill_idx_i;
         sram_wdata = {1'b1, bus.fill_tag_i};
      end else if (lookup_gnt) begin
         sram_req = '1;
      end
   end

   for (genvar w = 0; w < NumWays; w++) begin : gen_way
      tc_sram_impl #(
         .NumWords   (NumSets),
         .DataWidth  (WordWidth),
         .impl_in_t  (impl_in_t),
         .impl_out_t (impl_out_t)
      ) i_sram (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .impl_i  (impl_i),
         .impl_o  (unused_impl_o[w]),
         .req_i   (sram_req[w]),
         .we_i    (sram_we),
         .addr_i  (sram_addr),
         .wdata_i (sram_wdata),
         .rdata_o (rdata[w])
      );

      assign way_valid[w] = rdata[w][TagWidth];
      assign way_match[w] = way_valid[w] && (rdata[w][TagWidth-1:0] == lookup_tag_q);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= FLUSH;
         flush_busy_q <= 1'b1;
         flush_cnt    <= '0;
         rr_ptr       <= '0;
         rsp_pending  <= 1'b0;
         lookup_tag_q <= '0;
      end else begin
         // Response owed for a lookup is delivered regardless of a new flush.
         rsp_pending <= lookup_gnt;
         if (lookup_gnt) begin
            lookup_tag_q <= bus.lookup_tag_i;
         end
         if (fill_gnt) begin
            rr_ptr <= (rr_ptr == PtrWidth'(NumWays - 1)) ? '0 : rr_ptr + PtrWidth'(1);
         end
         if (state == IDLE) begin
            if (bus.flush_i) begin
               state        <= FLUSH;
               flush_busy_q <= 1'b1;
               flush_cnt    <= '0;
            end
         end else begin
            if (bus.flush_i) begin
               flush_cnt <= '0;
            end else if (flush_cnt == IdxWidth'(NumSets - 1)) begin
               state        <= IDLE;
               flush_busy_q <= 1'b0;
               flush_cnt    <= '0;
            end else begin
               flush_cnt <= flush_cnt + IdxWidth'(1);
            end
         end
      end
   end

   cva6_icache_victim_sel #(
      .NumWays  (NumWays),
      .PtrWidth (PtrWidth)
   ) i_victim_sel (
      .valid  (way_valid),
      .rr_ptr (rr_ptr),
      .victim (victim)
   );

   assign bus.flush_busy_o = flush_busy_q;
   assign bus.fill_gnt_o   = fill_gnt;
   assign bus.lookup_gnt_o = lookup_gnt;
   assign bus.rsp_valid_o  = rsp_pending;
   assign bus.hit_way_o    = rsp_pending ? way_match : '0;
   assign bus.hit_o        = rsp_pending && (|way_match);
   assign bus.multi_hit_o  = rsp_pending && ($countones(way_match) > 1);
   assign bus.victim_way_o = rsp_pending ? victim : '0;

endmodule

// File: tb/tb_cva6_icache_tag_array.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic against a set/way array model.
module tb_cva6_icache_tag_array;

   localparam int unsigned Sets = 16;
   localparam int unsigned Ways = 4;
   localparam int unsigned TW   = 20;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic impl = 1'b0;

   cva6_icache_tag_array_if #(.NumSets(Sets), .NumWays(Ways), .TagWidth(TW)) bus ();

   cva6_icache_tag_array #(
      .NumSets  (Sets),
      .NumWays  (Ways),
      .TagWidth (TW)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .impl_i (impl),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: contents of every set/way, busy window, round-robin count, owed response.
   bit          m_valid [Sets][Ways];
   logic [TW-1:0] m_tag  [Sets][Ways];
   int          m_busy = 16;
   int          m_rr   = 0;
   bit          p_valid;
   bit          p_hit;
   bit          p_multi;
   logic [3:0]  p_hitway;
   logic [3:0]  p_victim;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 16;
      m_rr    = 0;
      p_valid = 0; p_hit = 0; p_multi = 0; p_hitway = '0; p_victim = '0;
      for (int s = 0; s < Sets; s++)
         for (int w = 0; w < Ways; w++) m_valid[s][w] = 0;
   endtask

   task automatic model_step(input bit fg, input bit lg);
      int idx;
      if (lg) begin
         idx      = int'(bus.lookup_idx_i);
         p_valid  = 1;
         p_hitway = '0;
         for (int w = 0; w < Ways; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == bus.lookup_tag_i) p_hitway[w] = 1'b1;
         p_hit    = (p_hitway != 0);
         p_multi  = ($countones(p_hitway) > 1);
         p_victim = 4'(1) << m_rr;
         for (int w = Ways - 1; w >= 0; w--)
            if (!m_valid[idx][w]) p_victim = 4'(1) << w;
      end else begin
         p_valid = 0; p_hit = 0; p_multi = 0; p_hitway = '0; p_victim = '0;
      end
      if (bus.flush_i) begin
         m_busy = 16;
         for (int s = 0; s < Sets; s++)
            for (int w = 0; w < Ways; w++) m_valid[s][w] = 0;
      end else if (m_busy > 0) begin
         m_busy--;
      end
      if (fg) begin
         for (int w = 0; w < Ways; w++) begin
            if (bus.fill_way_i[w]) begin
               m_valid[int'(bus.fill_idx_i)][w] = 1;
               m_tag[int'(bus.fill_idx_i)][w]   = bus.fill_tag_i;
            end
         end
         m_rr = (m_rr + 1) % Ways;
      end
   endtask

   // Per-cycle compare, just before each rising edge.
   initial begin
      bit e_fg, e_lg;
      forever begin
         @(negedge clk);
         #4;
         if (rst) model_reset();
         e_fg = bus.fill_req_i && (m_busy == 0) && !bus.flush_i;
         e_lg = bus.lookup_req_i && (m_busy == 0) && !bus.flush_i && !bus.fill_req_i;
         check("flush_busy", bus.flush_busy_o, (m_busy > 0));
         check("fill_gnt", bus.fill_gnt_o, e_fg);
         check("lookup_gnt", bus.lookup_gnt_o, e_lg);
         check("rsp_valid", bus.rsp_valid_o, p_valid);
         check("hit", bus.hit_o, p_hit);
         check("hit_way", bus.hit_way_o, p_hitway);
         check("multi_hit", bus.multi_hit_o, p_multi);
         check("victim_way", bus.victim_way_o, p_victim);
         if (!rst) model_step(e_fg, e_lg);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bus.flush_i      = 1'b0;
      bus.lookup_req_i = 1'b0;
      bus.lookup_idx_i = '0;
      bus.lookup_tag_i = '0;
      bus.fill_req_i   = 1'b0;
      bus.fill_idx_i   = '0;
      bus.fill_tag_i   = '0;
      bus.fill_way_i   = '0;
   endtask

   // Starts and ends at a falling edge.
   task automatic do_fill(input logic [3:0] idx, input logic [TW-1:0] tag, input logic [3:0] way);
      bus.fill_req_i = 1'b1;
      bus.fill_idx_i = idx;
      bus.fill_tag_i = tag;
      bus.fill_way_i = way;
      #4;
      check("dir_fill_gnt", bus.fill_gnt_o, 1);
      @(negedge clk);
      bus.fill_req_i = 1'b0;
   endtask

   task automatic do_lookup(input logic [3:0] idx, input logic [TW-1:0] tag,
                            output logic hit, output logic [3:0] hitway, output logic [3:0] victim);
      bus.lookup_req_i = 1'b1;
      bus.lookup_idx_i = idx;
      bus.lookup_tag_i = tag;
      #4;
      check("dir_lookup_gnt", bus.lookup_gnt_o, 1);
      @(negedge clk);
      bus.lookup_req_i = 1'b0;
      #4;
      check("dir_rsp_valid", bus.rsp_valid_o, 1);
      hit    = bus.hit_o;
      hitway = bus.hit_way_o;
      victim = bus.victim_way_o;
      @(negedge clk);
   endtask

   // Counts busy cycles from the current falling edge; bounded.
   task automatic count_busy(input string name, input bit probe_lookup, output int n);
      n = 0;
      bus.lookup_req_i = probe_lookup;
      for (int c = 0; c < 40; c++) begin
         #4;
         if (!bus.flush_busy_o) break;
         if (probe_lookup) check({name, "_gnt_blocked"}, bus.lookup_gnt_o, 0);
         n++;
         @(negedge clk);
      end
      @(negedge clk);
      bus.lookup_req_i = 1'b0;
   endtask

   initial begin
      logic       hit;
      logic [3:0] hw, vic;
      int         nb;
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      count_busy("boot", 1'b1, nb);
      check("boot_busy_cycles", nb, 16);
      @(negedge clk);

      // Four fills into one set wrap the round-robin pointer back to way 0.
      for (int w = 0; w < 4; w++) do_fill(4'd5, 20'h50000 + 20'(w), 4'(1) << w);
      do_lookup(4'd5, 20'h12345, hit, hw, vic);
      check("set5_miss_hit", hit, 0);
      check("set5_miss_victim", vic, 4'b0001);
      do_lookup(4'd5, 20'h50002, hit, hw, vic);
      check("set5_hit_way", hw, 4'b0100);

      do_fill(4'd3, 20'hABCDE, 4'b0100);
      do_lookup(4'd3, 20'hABCDE, hit, hw, vic);
      check("set3_hit", hit, 1);
      check("set3_hit_way", hw, 4'b0100);
      do_lookup(4'd3, 20'h12345, hit, hw, vic);
      check("set3_miss_hit", hit, 0);
      check("set3_miss_victim", vic, 4'b0001);

      // Simultaneous fill and lookup: fill wins, lookup follows.
      bus.fill_req_i   = 1'b1; bus.fill_idx_i = 4'd7; bus.fill_tag_i = 20'h77777; bus.fill_way_i = 4'b0001;
      bus.lookup_req_i = 1'b1; bus.lookup_idx_i = 4'd3; bus.lookup_tag_i = 20'hABCDE;
      #4;
      check("prio_fill_gnt", bus.fill_gnt_o, 1);
      check("prio_lookup_blocked", bus.lookup_gnt_o, 0);
      @(negedge clk);
      bus.fill_req_i = 1'b0;
      #4;
      check("prio_lookup_gnt", bus.lookup_gnt_o, 1);
      @(negedge clk);
      bus.lookup_req_i = 1'b0;
      #4;
      check("prio_rsp_hit_way", bus.hit_way_o, 4'b0100);
      @(negedge clk);

      // Lookup granted the cycle before flush still answers from old contents.
      do_fill(4'd2, 20'h22222, 4'b0010);
      bus.lookup_req_i = 1'b1; bus.lookup_idx_i = 4'd2; bus.lookup_tag_i = 20'h22222;
      @(negedge clk);
      bus.lookup_req_i = 1'b0;
      bus.flush_i      = 1'b1;
      #4;
      check("preflush_rsp_hit_way", bus.hit_way_o, 4'b0010);
      @(negedge clk);
      bus.flush_i = 1'b0;
      count_busy("flush1", 1'b0, nb);
      check("flush1_busy_cycles", nb, 16);

      // Refill, start a sweep, restart it at set 9.
      do_fill(4'd3, 20'hABCDE, 4'b0100);
      bus.flush_i = 1'b1;
      @(negedge clk);
      bus.flush_i = 1'b0;
      repeat (9) @(negedge clk);
      bus.flush_i = 1'b1;
      #4;
      check("restart_busy", bus.flush_busy_o, 1);
      @(negedge clk);
      bus.flush_i = 1'b0;
      count_busy("restart", 1'b1, nb);
      check("restart_busy_cycles", nb, 16);
      @(negedge clk);
      do_lookup(4'd3, 20'hABCDE, hit, hw, vic);
      check("post_flush_miss", hit, 0);
      check("post_flush_victim", vic, 4'b0001);

      // Randomized traffic with a small tag/index space to force hits and multi-hits.
      for (int c = 0; c < 3000; c++) begin
         rst = (c >= 1500 && c < 1503);
         bus.flush_i      = ($urandom_range(0, 99) < 1);
         bus.fill_req_i   = ($urandom_range(0, 99) < 30);
         bus.fill_idx_i   = 4'($urandom_range(0, 3));
         bus.fill_tag_i   = 20'h300 + 20'($urandom_range(0, 3));
         bus.fill_way_i   = 4'($urandom_range(0, 15));
         bus.lookup_req_i = ($urandom_range(0, 99) < 50);
         bus.lookup_idx_i = 4'($urandom_range(0, 3));
         bus.lookup_tag_i = 20'h300 + 20'($urandom_range(0, 3));
         @(negedge clk);
      end
      rst = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
